// File: rtl/axi_mst_rd_fetch.sv
// AXI4 burst-read initiator: one command in flight, R beats forwarded through a one-entry
// valid/ready output register, completion pulse with sticky error status.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module axi_mst_rd_fetch #(
   parameter logic [`AXI_ID_WIDTH-1:0]   MST_ID   = '0,
   parameter logic [`AXI_SIZE_WIDTH-1:0] ARSIZE_V = `AXI_SIZE_WIDTH'(2)
) (
   input  logic                          clk,
   input  logic                          rst,
   // client command
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [`AXI_ADDR_WIDTH-1:0]    req_addr,
   input  logic [`AXI_LEN_WIDTH-1:0]     req_len,
   // client response
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [`AXI_DATA_WIDTH-1:0]    rsp_data,
   output logic                          rsp_last,
   output logic                          done,
   output logic                          err_resp,
   output logic                          err_last,
   // AXI AR channel
   output logic                          axi_mst_arvalid,
   input  logic                          axi_mst_arready,
   output logic [`AXI_ID_WIDTH-1:0]      axi_mst_arid,
   output logic [`AXI_ADDR_WIDTH-1:0]    axi_mst_araddr,
   output logic [`AXI_LEN_WIDTH-1:0]     axi_mst_arlen,
   output logic [`AXI_SIZE_WIDTH-1:0]    axi_mst_arsize,
   output logic [`AXI_BURST_WIDTH-1:0]   axi_mst_arburst,
   output logic [`AXI_LOCK_WIDTH-1:0]    axi_mst_arlock,
   output logic [`AXI_CACHE_WIDTH-1:0]   axi_mst_arcache,
   output logic [`AXI_PROT_WIDTH-1:0]    axi_mst_arprot,
   output logic [`AXI_QOS_WIDTH-1:0]     axi_mst_arqos,
   output logic [`AXI_REGION_WIDTH-1:0]  axi_mst_arregion,
   // AXI R channel
   input  logic                          axi_mst_rvalid,
   output logic                          axi_mst_rready,
   input  logic [`AXI_ID_WIDTH-1:0]      axi_mst_rid,
   input  logic [`AXI_DATA_WIDTH-1:0]    axi_mst_rdata,
   input  logic [`AXI_RESP_WIDTH-1:0]    axi_mst_rresp,
   input  logic                          axi_mst_rlast
);

   localparam int unsigned CntW = `AXI_LEN_WIDTH + 1;

   typedef enum logic [1:0] {StIdle, StAr, StData, StDone} state_e;

   state_e                       state_q, state_d;
   logic [`AXI_ADDR_WIDTH-1:0]   addr_q;
   logic [`AXI_LEN_WIDTH-1:0]    len_q;
   logic [CntW-1:0]              cnt_q;
   logic [CntW-1:0]              len_ext;
   logic                         err_resp_q, err_last_q;
   logic                         rsp_valid_q, rsp_last_q;
   logic [`AXI_DATA_WIDTH-1:0]   rsp_data_q;
   logic                         done_c;
   logic                         r_hs, at_len, fwd, rsp_take;

   assign len_ext  = {1'b0, len_q};
   assign r_hs     = axi_mst_rvalid & axi_mst_rready;
   assign at_len   = (cnt_q == len_ext);
   assign fwd      = r_hs & (cnt_q <= len_ext);
   assign rsp_take = rsp_valid_q & rsp_ready;

   always_comb begin
      state_d         = state_q;
      req_ready       = 1'b0;
      axi_mst_arvalid = 1'b0;
      axi_mst_rready  = 1'b0;
      done_c          = 1'b0;
      case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) state_d = StAr;
         end
         StAr: begin
            axi_mst_arvalid = 1'b1;
            if (axi_mst_arready) state_d = StData;
         end
         StData: begin
            // Accept a beat whenever the output register is empty or drains this cycle.
            axi_mst_rready = !rsp_valid_q | rsp_ready;
            if (axi_mst_rvalid && axi_mst_rready && axi_mst_rlast) state_d = StDone;
         end
         StDone: begin
            if (!rsp_valid_q || rsp_ready) begin
               done_c  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         err_resp_q  <= 1'b0;
         err_last_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && req_valid) begin
            addr_q     <= req_addr;
            len_q      <= req_len;
            cnt_q      <= '0;
            err_resp_q <= 1'b0;
            err_last_q <= 1'b0;
         end
         if (r_hs) begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (axi_mst_rresp != '0 || axi_mst_rid != MST_ID) err_resp_q <= 1'b1;
            // rlast must coincide exactly with the len-th beat
            if (axi_mst_rlast ^ at_len) err_last_q <= 1'b1;
         end
         if (fwd) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= axi_mst_rdata;
            rsp_last_q  <= at_len | axi_mst_rlast;
         end else if (rsp_take) begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_last  = rsp_last_q;
   assign done      = done_c;
   assign err_resp  = done_c & err_resp_q;
   assign err_last  = done_c & err_last_q;

   assign axi_mst_arid     = MST_ID;
   assign axi_mst_araddr   = addr_q & ~(`AXI_ADDR_WIDTH'(3));
   assign axi_mst_arlen    = len_q;
   assign axi_mst_arsize   = ARSIZE_V;
   assign axi_mst_arburst  = `AXI_BURST_WIDTH'(1);
   assign axi_mst_arlock   = '0;
   assign axi_mst_arcache  = '0;
   assign axi_mst_arprot   = '0;
   assign axi_mst_arqos    = '0;
   assign axi_mst_arregion = '0;

endmodule

// File: tb/tb_axi_mst_rd_fetch.sv
// Self-checking bench for axi_mst_rd_fetch: procedural AXI read slave plus a scoreboard of
// expected client beats, compared by a negedge monitor.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module tb_axi_mst_rd_fetch;

   localparam logic [3:0] MstId = 4'd5;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic [7:0]  req_len;
   logic        rsp_valid, rsp_ready, rsp_last;
   logic [31:0] rsp_data;
   logic        done, err_resp, err_last;
   logic        arvalid, arready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [0:0]  arlock;
   logic [3:0]  arcache, arqos, arregion;
   logic [2:0]  arprot;
   logic        rvalid, rready, rlast;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [32:0] sb_q[$];
   logic [32:0] mon_exp;
   bit          rdy_toggle = 1'b0;

   axi_mst_rd_fetch #(.MST_ID(MstId), .ARSIZE_V(3'd2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .done(done), .err_resp(err_resp), .err_last(err_last),
      .axi_mst_arvalid(arvalid), .axi_mst_arready(arready), .axi_mst_arid(arid),
      .axi_mst_araddr(araddr), .axi_mst_arlen(arlen), .axi_mst_arsize(arsize),
      .axi_mst_arburst(arburst), .axi_mst_arlock(arlock), .axi_mst_arcache(arcache),
      .axi_mst_arprot(arprot), .axi_mst_arqos(arqos), .axi_mst_arregion(arregion),
      .axi_mst_rvalid(rvalid), .axi_mst_rready(rready), .axi_mst_rid(rid),
      .axi_mst_rdata(rdata), .axi_mst_rresp(rresp), .axi_mst_rlast(rlast)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Client side: compare forwarded beats against the scoreboard.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) check_eq("rsp_extra", sb_q.size(), 1);
         else begin
            mon_exp = sb_q.pop_front();
            check_eq("rsp_data", rsp_data, mon_exp[31:0]);
            check_eq("rsp_last", rsp_last, mon_exp[32]);
         end
      end
      if (!rst && rsp_valid && !rsp_ready) begin
         check_eq("rready_bp", rready, 1'b0);
         if (sb_q.size() > 0) check_eq("rsp_hold", rsp_data, sb_q[0][31:0]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [31:0] addr, input logic [7:0] len);
      req_valid = 1'b1;
      req_addr  = addr;
      req_len   = len;
      @(negedge clk);
      check_eq("req_ready", req_ready, 1'b1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len, input int delay);
      int t;
      arready = 1'b0;
      for (int k = 0; k < delay; k++) begin
         @(negedge clk);
         check_eq("ar_hold_valid", arvalid, 1'b1);
         check_eq("ar_hold_addr", araddr, {addr[31:2], 2'b00});
         check_eq("ar_hold_len", arlen, len);
         check_eq("ar_req_ready", req_ready, 1'b0);
         step();
      end
      arready = 1'b1;
      t = 0;
      @(negedge clk);
      while (!arvalid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_eq("arvalid", arvalid, 1'b1);
      check_eq("araddr", araddr, {addr[31:2], 2'b00});
      check_eq("arlen", arlen, len);
      check_eq("ar_const", {arid, arsize, arburst, arlock, arcache, arprot, arqos, arregion},
               {MstId, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
      step();
      arready = 1'b0;
   endtask

   task automatic send_beat(input int i, input logic [31:0] data, input logic last,
                            input logic [1:0] resp, input logic [3:0] id, input int len);
      int t;
      rvalid = 1'b1;
      rdata  = data;
      rlast  = last;
      rresp  = resp;
      rid    = id;
      t = 0;
      @(negedge clk);
      while (!rready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_eq("rready_wait", rready, 1'b1);
      @(posedge clk);
      if (i <= len) sb_q.push_back({(i == len) | last, data});
      #1;
   endtask

   task automatic wait_done(input logic exp_resp, input logic exp_last, input bit chk_lat);
      int t;
      t = 0;
      @(negedge clk);
      while (!done && t < 100) begin
         @(negedge clk);
         t++;
      end
      check_eq("done_seen", done, 1'b1);
      if (chk_lat) check_eq("done_lat", t, 0);
      check_eq("err_resp", err_resp, exp_resp);
      check_eq("err_last", err_last, exp_last);
      @(negedge clk);
      check_eq("done_pulse", done, 1'b0);
      check_eq("req_ready_after", req_ready, 1'b1);
      check_eq("sb_empty", sb_q.size(), 0);
      step();
   endtask

   task automatic run_cmd(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                          input int last_idx, input int err_idx, input int bad_id_idx,
                          input int ar_delay, input logic exp_resp, input logic exp_last,
                          input bit chk_lat);
      send_req(addr, len);
      ar_phase(addr, len, ar_delay);
      for (int i = 0; i < nbeats; i++) begin
         send_beat(i, $urandom, i == last_idx, (i == err_idx) ? 2'b10 : 2'b00,
                   (i == bad_id_idx) ? ~MstId : MstId, int'(len));
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      wait_done(exp_resp, exp_last, chk_lat);
   endtask

   // Client ready: constantly high, or alternating every cycle.
   initial begin
      rsp_ready = 1'b1;
      forever begin
         step();
         rsp_ready = rdy_toggle ? ~rsp_ready : 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_addr = '0;
      req_len = '0;
      arready = 1'b0;
      rvalid = 1'b0;
      rid = MstId;
      rdata = '0;
      rresp = '0;
      rlast = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_outputs", {req_ready, arvalid, rready, rsp_valid, rsp_last, done,
                               err_resp, err_last}, 8'b1000_0000);
      step();
      rst = 1'b0;

      // basic burst, then a misaligned address
      run_cmd(32'h100, 8'd3, 4, 3, -1, -1, 0, 1'b0, 1'b0, 1'b1);
      run_cmd(32'h10A, 8'd0, 1, 0, -1, -1, 0, 1'b0, 1'b0, 1'b1);
      // client backpressure
      rdy_toggle = 1'b1;
      run_cmd(32'h2000, 8'd7, 8, 7, -1, -1, 0, 1'b0, 1'b0, 1'b0);
      rdy_toggle = 1'b0;
      step();
      // AR stall
      run_cmd(32'h3004, 8'd2, 3, 2, -1, -1, 5, 1'b0, 1'b0, 1'b0);
      // SLVERR on beat 2, then wrong RID
      run_cmd(32'h400, 8'd3, 4, 3, 1, -1, 0, 1'b1, 1'b0, 1'b0);
      run_cmd(32'h500, 8'd1, 2, 1, -1, 0, 0, 1'b1, 1'b0, 1'b0);
      // early rlast, then late rlast
      run_cmd(32'h600, 8'd3, 2, 1, -1, -1, 0, 1'b0, 1'b1, 1'b0);
      run_cmd(32'h700, 8'd1, 4, 3, -1, -1, 0, 1'b0, 1'b1, 1'b0);

      // reset mid-burst after the first beat
      send_req(32'h800, 8'd3);
      ar_phase(32'h800, 8'd3, 0);
      send_beat(0, $urandom, 1'b0, 2'b00, MstId, 3);
      rvalid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_mid", {arvalid, rready, rsp_valid, req_ready}, 4'b0001);
      sb_q.delete();
      step();
      run_cmd(32'h900, 8'd3, 4, 3, -1, -1, 0, 1'b0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
